// File: rtl/vga_line_pingpong_pkg.sv
// Shared definitions for the VGA line ping-pong buffer: pixel width,
// colour field positions and the per-bank fill state.
package vga_pkg;

  // Pixel width and colour field layout {blue, green, red}
  localparam int DW        = 12;
  localparam int RED_LSB   = 0;
  localparam int RED_MSB   = 3;
  localparam int GREEN_LSB = 4;
  localparam int GREEN_MSB = 7;
  localparam int BLUE_LSB  = 8;
  localparam int BLUE_MSB  = 11;

  // A bank is either being filled (EMPTY) or holding a complete line (FULL)
  typedef enum logic {
    BANK_EMPTY = 1'b0,
    BANK_FULL  = 1'b1
  } bankState_e;

endpackage

// File: rtl/vga_line_pingpong_bank.sv
// One line bank: DEPTH x DW storage with a synchronous write port and an
// asynchronous read port. Contents are deliberately not reset.
module vga_line_bank #(
  parameter int DW    = 12,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  // Store one pixel per accepted write
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Zero-latency read so the controller sees the pixel in the request cycle
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/vga_line_pingpong.sv
// Two-bank ping-pong line buffer in front of the VGA timing controller.
// The fetch side fills the EMPTY write bank while the controller drains the
// FULL read bank; banks swap when a line completes on either side.
module vga_line_pingpong #(
  parameter  int DW    = vga_pkg::DW,
  parameter  int DEPTH = 1024,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic [AW:0]   line_len_i,
  input  logic          wr_valid_i,
  input  logic [DW-1:0] wr_data_i,
  output logic          wr_ready_o,
  input  logic          data_req_i,
  output logic [DW-1:0] data_o,
  output logic [1:0]    full_cnt_o,
  output logic          underrun_o
);

  import vga_pkg::*;

  bankState_e [1:0] bankState_q, bankState_d;
  logic             wrBank_q, wrBank_d;
  logic             rdBank_q, rdBank_d;
  logic [AW-1:0]    wrPtr_q, wrPtr_d;
  logic [AW-1:0]    rdPtr_q, rdPtr_d;
  logic             underrun_q, underrun_d;

  logic [AW:0]      lineLast;
  logic             wrReady;
  logic             rdFull;
  logic             wrFire;
  logic             rdFire;
  logic             wrLast;
  logic             rdLast;
  logic [DW-1:0]    rdData0;
  logic [DW-1:0]    rdData1;
  logic [DW-1:0]    rdData;

  assign lineLast = line_len_i - (AW+1)'(1);
  assign wrReady  = (bankState_q[wrBank_q] == BANK_EMPTY);
  assign rdFull   = (bankState_q[rdBank_q] == BANK_FULL);
  assign wrFire   = wr_valid_i & wrReady & ~flush_i;
  assign rdFire   = data_req_i & rdFull & ~flush_i;
  assign wrLast   = ({1'b0, wrPtr_q} == lineLast);
  assign rdLast   = ({1'b0, rdPtr_q} == lineLast);

  vga_line_bank #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_bank0 (
    .clk     (clk),
    .we_i    (wrFire & (wrBank_q == 1'b0)),
    .waddr_i (wrPtr_q),
    .wdata_i (wr_data_i),
    .raddr_i (rdPtr_q),
    .rdata_o (rdData0)
  );

  vga_line_bank #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_bank1 (
    .clk     (clk),
    .we_i    (wrFire & (wrBank_q == 1'b1)),
    .waddr_i (wrPtr_q),
    .wdata_i (wr_data_i),
    .raddr_i (rdPtr_q),
    .rdata_o (rdData1)
  );

  assign rdData = rdBank_q ? rdData1 : rdData0;

  // Outputs depend only on registered state, never on the request/valid inputs
  assign wr_ready_o = wrReady;
  assign data_o     = rdFull ? rdData : '0;
  assign full_cnt_o = {1'b0, (bankState_q[0] == BANK_FULL)}
                    + {1'b0, (bankState_q[1] == BANK_FULL)};
  assign underrun_o = underrun_q;

  // Next-state: flush wins; otherwise write and read sides advance independently
  always_comb begin
    bankState_d = bankState_q;
    wrBank_d    = wrBank_q;
    rdBank_d    = rdBank_q;
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    underrun_d  = underrun_q;

    if (flush_i) begin
      bankState_d = {BANK_EMPTY, BANK_EMPTY};
      wrBank_d    = 1'b0;
      rdBank_d    = 1'b0;
      wrPtr_d     = '0;
      rdPtr_d     = '0;
      underrun_d  = 1'b0;
    end else begin
      if (wrFire) begin
        if (wrLast) begin
          bankState_d[wrBank_q] = BANK_FULL;
          wrPtr_d               = '0;
          wrBank_d              = ~wrBank_q;
        end else begin
          wrPtr_d = wrPtr_q + AW'(1);
        end
      end

      if (rdFire) begin
        if (rdLast) begin
          bankState_d[rdBank_q] = BANK_EMPTY;
          rdPtr_d               = '0;
          rdBank_d              = ~rdBank_q;
        end else begin
          rdPtr_d = rdPtr_q + AW'(1);
        end
      end else if (data_req_i) begin
        underrun_d = 1'b1;
      end
    end
  end

  // Control state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      bankState_q <= {BANK_EMPTY, BANK_EMPTY};
      wrBank_q    <= 1'b0;
      rdBank_q    <= 1'b0;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      underrun_q  <= 1'b0;
    end else begin
      bankState_q <= bankState_d;
      wrBank_q    <= wrBank_d;
      rdBank_q    <= rdBank_d;
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      underrun_q  <= underrun_d;
    end
  end

  // Line length must be within 1..DEPTH outside reset
  lineLenLegal: assert property (@(posedge clk) disable iff (rst)
    (line_len_i != '0) && (line_len_i <= (AW+1)'(DEPTH)));

endmodule

// File: tb/tb_vga_line_pingpong.sv
// Self-checking bench for vga_line_pingpong: directed scenarios plus random
// traffic, all compared cycle by cycle against a queue-based line model.
module tb_vga_line_pingpong;

  localparam int DW    = 12;
  localparam int DEPTH = 1024;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst;
  logic          flush_i;
  logic [AW:0]   line_len_i;
  logic          wr_valid_i;
  logic [DW-1:0] wr_data_i;
  logic          wr_ready_o;
  logic          data_req_i;
  logic [DW-1:0] data_o;
  logic [1:0]    full_cnt_o;
  logic          underrun_o;

  int errors = 0;
  int checks = 0;

  // Reference model: completed lines as one pixel stream, a pending partial line
  logic [DW-1:0] pix[$];
  logic [DW-1:0] pend[$];
  int            fullCount;
  int            rdIdx;
  bit            underrunM;
  logic [DW-1:0] nextPix;

  always #5 clk = ~clk;

  vga_line_pingpong #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush_i),
    .line_len_i (line_len_i),
    .wr_valid_i (wr_valid_i),
    .wr_data_i  (wr_data_i),
    .wr_ready_o (wr_ready_o),
    .data_req_i (data_req_i),
    .data_o     (data_o),
    .full_cnt_o (full_cnt_o),
    .underrun_o (underrun_o)
  );

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic modelClear();
    pix.delete();
    pend.delete();
    fullCount = 0;
    rdIdx     = 0;
    underrunM = 1'b0;
  endtask

  // Compare all DUT outputs with what the model predicts for this cycle
  task automatic compareModel();
    logic [DW-1:0] expData;
    expData = (fullCount > 0) ? pix[0] : '0;
    checkOutput("wr_ready", 32'(wr_ready_o), 32'(fullCount < 2));
    checkOutput("data",     32'(data_o),     32'(expData));
    checkOutput("full_cnt", 32'(full_cnt_o), 32'(fullCount));
    checkOutput("underrun", 32'(underrun_o), 32'(underrunM));
  endtask

  // Advance the model by one clock edge given the inputs applied in that cycle
  task automatic modelStep(input bit f, input int len, input bit wv,
                           input logic [DW-1:0] wd, input bit req);
    bit preReady;
    bit preFull;
    if (f) begin
      modelClear();
      return;
    end
    preReady = (fullCount < 2);
    preFull  = (fullCount > 0);
    if (req) begin
      if (preFull) begin
        void'(pix.pop_front());
        rdIdx++;
        if (rdIdx == len) begin
          fullCount--;
          rdIdx = 0;
        end
      end else begin
        underrunM = 1'b1;
      end
    end
    if (wv && preReady) begin
      pend.push_back(wd);
      if (pend.size() == len) begin
        foreach (pend[k]) pix.push_back(pend[k]);
        pend.delete();
        fullCount++;
      end
    end
  endtask

  // Drive one cycle of inputs (called just after a falling edge), check, clock
  task automatic applyStimulus(input bit f, input int len, input bit wv,
                               input logic [DW-1:0] wd, input bit req);
    flush_i    = f;
    line_len_i = (AW+1)'(len);
    wr_valid_i = wv;
    wr_data_i  = wd;
    data_req_i = req;
    compareModel();
    @(posedge clk);
    modelStep(f, len, wv, wd, req);
    @(negedge clk);
  endtask

  initial begin
    int curLen;
    rst        = 1'b1;
    flush_i    = 1'b0;
    line_len_i = (AW+1)'(4);
    wr_valid_i = 1'b0;
    wr_data_i  = '0;
    data_req_i = 1'b0;
    modelClear();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state, then one 4-pixel line into bank 0
    checkOutput("rst_wr_ready", 32'(wr_ready_o), 32'd1);
    checkOutput("rst_data",     32'(data_o),     32'd0);
    checkOutput("rst_full_cnt", 32'(full_cnt_o), 32'd0);
    checkOutput("rst_underrun", 32'(underrun_o), 32'd0);
    for (int i = 1; i <= 4; i++) applyStimulus(0, 4, 1, DW'(i), 0);
    checkOutput("line0_data",     32'(data_o),     32'h001);
    checkOutput("line0_full_cnt", 32'(full_cnt_o), 32'd1);
    checkOutput("line0_ready",    32'(wr_ready_o), 32'd1);

    // Second line, then eight back-to-back requests across the swap
    for (int i = 5; i <= 8; i++) applyStimulus(0, 4, 1, DW'(i), 0);
    for (int i = 1; i <= 8; i++) begin
      checkOutput("drain_seq", 32'(data_o), 32'(i));
      applyStimulus(0, 4, 0, '0, 1);
    end
    applyStimulus(0, 4, 0, '0, 0);

    // Both banks full with valid held high, then drain releases the write bank
    applyStimulus(1, 4, 0, '0, 0);
    for (int i = 0; i < 11; i++) applyStimulus(0, 4, 1, DW'(12'h100 + i), 0);
    for (int i = 0; i < 6; i++) applyStimulus(0, 4, 1, DW'(12'h200 + i), 1);
    for (int i = 0; i < 10; i++) applyStimulus(0, 4, 0, '0, 1);

    // Underrun on empty banks stays sticky across later valid reads
    applyStimulus(1, 4, 0, '0, 0);
    applyStimulus(0, 4, 0, '0, 1);
    applyStimulus(0, 4, 0, '0, 1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 4, 1, DW'(12'h300 + i), 0);
    checkOutput("underrun_word0", 32'(data_o), 32'h300);
    for (int i = 0; i < 4; i++) applyStimulus(0, 4, 0, '0, 1);
    checkOutput("underrun_sticky", 32'(underrun_o), 32'd1);

    // Partial line discarded by a flush that coincides with a write
    applyStimulus(0, 4, 1, 12'h401, 0);
    applyStimulus(0, 4, 1, 12'h402, 0);
    applyStimulus(1, 4, 1, 12'h403, 1);
    checkOutput("flush_underrun", 32'(underrun_o), 32'd0);
    checkOutput("flush_full_cnt", 32'(full_cnt_o), 32'd0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 4, 1, DW'(12'h500 + i), 0);
    checkOutput("flush_word0", 32'(data_o), 32'h500);

    // Single-pixel lines exercise the zero-length pointer range
    applyStimulus(1, 1, 0, '0, 0);
    for (int i = 0; i < 12; i++) applyStimulus(0, 1, ($urandom_range(0, 3) != 0), DW'($urandom), $urandom_range(0, 1) == 1);

    // Full-depth lines: fill, overlap fill with drain, then drain
    applyStimulus(1, DEPTH, 0, '0, 0);
    for (int i = 0; i < DEPTH; i++) applyStimulus(0, DEPTH, 1, DW'($urandom), 0);
    for (int i = 0; i < DEPTH; i++) applyStimulus(0, DEPTH, 1, DW'($urandom), 1);
    for (int i = 0; i < DEPTH + 2; i++) applyStimulus(0, DEPTH, 0, '0, 1);

    // Random traffic with occasional flushes that pick a new line length
    curLen = 4;
    applyStimulus(1, curLen, 0, '0, 0);
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 99) < 2) begin
        curLen = $urandom_range(1, 9);
        applyStimulus(1, curLen, $urandom_range(0, 1) == 1, DW'($urandom), $urandom_range(0, 1) == 1);
      end else begin
        nextPix = DW'($urandom);
        applyStimulus(0, curLen, $urandom_range(0, 9) < 7, nextPix, $urandom_range(0, 9) < 6);
      end
    end
    compareModel();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_line_pingpong.md
# vga_line_pingpong

Two-bank ping-pong line buffer sitting directly upstream of the VGA timing controller. A pixel fetch engine fills one bank with a scan line while the controller drains the other. The drain side answers the controller's `data_req` with a zero-latency `data_o`, so the controller can register the pixel in the same cycle it asserts the request. Banks swap automatically on line completion, and a `flush_i` pulse per frame re-aligns both sides.

## Interface
- `DW`, 12, pixel width: {blue[3:0], green[3:0], red[3:0]}
- `DEPTH`, 1024, words per bank; power of two
- `AW`, `$clog2(DEPTH)`, pointer width (derived; do not override)
- `clk`  in  1  sole clock
- `rst`  in  1  reset; synchronous, active-high
- `flush_i`  in  1  single-cycle pulse; empties both banks (issued at frame start)
- `line_len_i`  in  AW+1  pixels per line, 1..DEPTH; static except in the flush cycle
- `wr_valid_i`  in  1  fetch-side pixel valid
- `wr_data_i`  in  DW  fetch-side pixel
- `wr_ready_o`  out  1  write bank can accept a pixel
- `data_req_i`  in  1  controller consumes `data_o` this cycle
- `data_o`  out  DW  current pixel of the read bank
- `full_cnt_o`  out  2  number of banks in state FULL (0..2)
- `underrun_o`  out  1  sticky; set when a request finds no FULL read bank

## Operation
- Per-bank state: EMPTY or FULL. Write pointer `wr_bank`/`wr_ptr`; read pointer `rd_bank`/`rd_ptr`.
- Write: `wr_ready_o = (state[wr_bank] == EMPTY)`. On `wr_valid_i & wr_ready_o`:
  - store at `[wr_bank][wr_ptr]`, then `wr_ptr++`.
  - If `wr_ptr == line_len_i-1`: bank becomes FULL, `wr_ptr` goes to 0, `wr_bank` toggles.
- Read: `data_o = mem[rd_bank][rd_ptr]` when `state[rd_bank] == FULL`, else 0. On `data_req_i` with the read bank FULL:
  - `rd_ptr++`.
  - If `rd_ptr == line_len_i-1`: bank becomes EMPTY, `rd_ptr` goes to 0, `rd_bank` toggles.
- Underrun: on `data_req_i` with the read bank not FULL:
  - `data_o = 0`, `underrun_o` is set, pointers hold.
  - `underrun_o` clears only on `rst` or `flush_i`.
- Same-bank hazard is impossible: a bank is written only when EMPTY and read only when FULL.
- Simultaneous write-completion and read-completion on opposite banks both take effect in the same cycle.
- `flush_i` has priority over all traffic in its cycle:
  - both banks go EMPTY, all pointers and banks go to 0, `underrun_o` goes to 0.
  - A write or request in that cycle is dropped.
- `line_len_i == 0` is illegal. Behaviour is undefined; assertion only.
- Storage has no reset (array of flops or distributed RAM, asynchronous read).

## Timing
- Reset values (cycle after `rst`):
  - both banks EMPTY, pointers 0
  - `wr_ready_o=1`, `data_o=0`, `full_cnt_o=0`, `underrun_o=0`
- Write-to-read latency: the last pixel of a line is written at edge N. From cycle N+1 that bank is FULL, `data_o` shows pixel 0, and `full_cnt_o` is incremented.
- Read latency: 0. `data_o` is valid in the same cycle `data_req_i` is high, and advances at the following edge.
- `wr_ready_o`, `data_o` and `full_cnt_o` are combinational from registered state. There is no path from `data_req_i` or `wr_valid_i` to any output.
- A `rst` or `flush_i` mid-line discards the partial line. The first post-flush write goes to bank 0, word 0.
- Throughput: one write and one read per cycle, sustained.

## Structure
- Shared package `vga_pkg`: `DW`, the pixel field slices (`RED`/`GREEN`/`BLUE` ranges), bank state enum `{BANK_EMPTY, BANK_FULL}`.
- One sub-module: `vga_line_bank` (one DEPTH×DW array, synchronous write, asynchronous read), instantiated twice. Control stays in the top.

## Test plan
- Reset, `line_len_i=4`, write 0x001..0x004:
  - `wr_ready_o` stays 1 (bank1 EMPTY), `full_cnt_o=1`, `data_o=0x001` next cycle.
- Continue with 4 more writes (0x005..0x008), then 8 back-to-back requests:
  - `data_o` sequence 0x001..0x008, bank swap with no bubble.
  - `full_cnt_o` goes 2→1→0, `underrun_o=0`.
- Fill both banks (`line_len_i=4`), keep `wr_valid_i` high:
  - `wr_ready_o=0`, no write accepted.
  - First request completing bank0 raises `wr_ready_o` the next cycle.
- Request with both banks EMPTY:
  - `data_o=0`, `underrun_o=1` and stays high through later valid reads.
  - Pointers unchanged: first real pixel is still word 0.
- Two pixels into bank0, then `flush_i` asserted together with `wr_valid_i`:
  - write dropped, all EMPTY, `underrun_o=0`.
  - Next write lands at bank0 word 0.
- `line_len_i=DEPTH`, full-line fill then drain:
  - `wr_ptr`/`rd_ptr` wrap to 0 at word 1023.
  - Banks toggle, data integrity 100%.
